codec_init_sequencer: RTL and testbench

//  Hardware Avalon-MM master that configures the WM8731 after power-up, replacing the bench-only

---
 rtl/codec_init_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
// Avalon-MM master that walks the WM8731 init table after power-up: read-modify-write of the
// I2C data register per packet, then poll status with bounded retries on nack or timeout.
module codec_init_sequencer #(
  parameter logic [2:0]  ADDR_I2C_DATA   = 3'h0,
  parameter logic [2:0]  ADDR_I2C_STATUS = 3'h1,
  parameter int unsigned NUM_WORDS       = 11,
  parameter int unsigned POLL_TIMEOUT    = 1024,
  parameter int unsigned MAX_RETRY       = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  err_index,
  output logic        master_read,
  output logic        master_write,
  output logic        master_chipselect,
  output logic [2:0]  master_address,
  output logic [31:0] master_writedata,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest
);

  typedef enum logic [2:0] {
    StIdle, StRdData, StWrData, StPoll, StCheck, StNext, StDone, StErr
  } state_e;

  localparam logic [10:0] PollMax  = 11'(POLL_TIMEOUT);
  localparam logic [3:0]  RetryMax = 4'(MAX_RETRY);
  localparam logic [3:0]  LastIdx  = 4'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  retry_q, retry_d;
  logic [10:0] poll_q, poll_d;
  logic [1:0]  stat_q, stat_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  err_index_q, err_index_d;
  logic        done_q, done_d, error_q, error_d, busy_q, busy_d;
  logic        read_q, read_d, write_q, write_d;
  logic [2:0]  addr_q, addr_d;
  logic        accept, fail;

  function automatic logic [23:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = 24'h341E00;
      4'd1:    table_word = 24'h340017;
      4'd2:    table_word = 24'h340217;
      4'd3:    table_word = 24'h340479;
      4'd4:    table_word = 24'h340679;
      4'd5:    table_word = 24'h340812;
      4'd6:    table_word = 24'h340A00;
      4'd7:    table_word = 24'h340C00;
      4'd8:    table_word = 24'h340E02;
      4'd9:    table_word = 24'h341000;
      4'd10:   table_word = 24'h341201;
      default: table_word = 24'h000000;
    endcase
  endfunction

  assign accept = (read_q | write_q) & ~master_waitrequest;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    retry_d     = retry_q;
    poll_d      = poll_q;
    stat_d      = stat_q;
    wd_d        = wd_q;
    err_index_d = err_index_q;
    done_d      = done_q;
    error_d     = error_q;
    fail        = 1'b0;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StRdData;
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = 4'd0;
          retry_d = 4'd0;
        end
      end
      StRdData: begin
        if (accept) begin
          wd_d    = {master_readdata[31:24], table_word(index_q)};
          state_d = StWrData;
        end
      end
      StWrData: begin
        if (accept) begin
          poll_d  = 11'd0;
          state_d = StPoll;
        end
      end
      StPoll: begin
        if (accept) begin
          stat_d  = master_readdata[1:0];
          if (poll_q != PollMax) poll_d = poll_q + 11'd1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Busy takes priority over nack: a still-running transaction is never judged.
        if (stat_q[0]) begin
          if (poll_q < PollMax) state_d = StPoll;
          else                  fail    = 1'b1;
        end else if (stat_q[1]) begin
          fail = 1'b1;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (index_q == LastIdx) begin
          state_d = StDone;
        end else begin
          index_d = index_q + 4'd1;
          retry_d = 4'd0;
          state_d = StRdData;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 4'd1;
        state_d = StRdData;
      end else begin
        err_index_d = index_q;
        state_d     = StErr;
      end
    end

    if (state_d == StDone) done_d  = 1'b1;
    if (state_d == StErr)  error_d = 1'b1;

    // Commands are registered from the next state so they rise on the entry edge and hold
    // through any stall until the accepting edge moves the FSM on.
    read_d  = (state_d == StRdData) || (state_d == StPoll);
    write_d = (state_d == StWrData);
    addr_d  = (state_d == StPoll) ? ADDR_I2C_STATUS : ADDR_I2C_DATA;
    busy_d  = !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      index_q     <= 4'd0;
      retry_q     <= 4'd0;
      poll_q      <= 11'd0;
      stat_q      <= 2'd0;
      wd_q        <= 32'd0;
      err_index_q <= 4'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      retry_q     <= retry_d;
      poll_q      <= poll_d;
      stat_q      <= stat_d;
      wd_q        <= wd_d;
      err_index_q <= err_index_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign err_index         = err_index_q;
  assign master_read       = read_q;
  assign master_write      = write_q;
  assign master_chipselect = read_q | write_q;
  assign master_address    = addr_q;
  assign master_writedata  = wd_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer: Avalon slave model with stall/busy/nack knobs and a
// write scoreboard of expected I2C data words.
module tb_codec_init_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [3:0]  err_index;
  logic        master_read, master_write, master_chipselect;
  logic [2:0]  master_address;
  logic [31:0] master_writedata, master_readdata;
  logic        master_waitrequest;

  codec_init_sequencer dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .err_index          (err_index),
    .master_read        (master_read),
    .master_write       (master_write),
    .master_chipselect  (master_chipselect),
    .master_address     (master_address),
    .master_writedata   (master_writedata),
    .master_readdata    (master_readdata),
    .master_waitrequest (master_waitrequest)
  );

  always #5 Clk = ~Clk;

  localparam logic [31:0] DataRd = 32'hAB5A5A5A;
  logic [23:0] tbl [0:10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                              24'h340812, 24'h340A00, 24'h340C00, 24'h340E02, 24'h341000,
                              24'h341201};

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_wr [$];

  // Slave knobs (driven by the stimulus block only).
  int          wait_cfg = 0;
  int          busy_cfg = 0;
  int          nack_cfg = 0;
  logic [23:0] nack_pkt = 24'h0;

  // Slave state.
  int          stall_cnt, pkt_reads, nack_used;
  logic [23:0] cur_pkt;
  logic        accept, busy_bit, nack_bit;

  // Monitor state.
  int          data_reads = 0, status_reads = 0;
  logic        prev_stall = 1'b0, prev_rd, prev_wr;
  logic [2:0]  prev_addr;
  logic [31:0] prev_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always_comb begin
    master_waitrequest = (master_read || master_write) && (stall_cnt < wait_cfg);
    accept   = (master_read || master_write) && !master_waitrequest;
    busy_bit = pkt_reads < busy_cfg;
    nack_bit = !busy_bit && (cur_pkt == nack_pkt) && (nack_used < nack_cfg);
    if (master_address == 3'h1) master_readdata = {30'd0, nack_bit, busy_bit};
    else                        master_readdata = DataRd;
  end

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= 0;
      pkt_reads <= 0;
      nack_used <= 0;
      cur_pkt   <= 24'h0;
    end else begin
      if ((master_read || master_write) && master_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      if (start) nack_used <= 0;
      if (accept && master_write) begin
        cur_pkt   <= master_writedata[23:0];
        pkt_reads <= 0;
      end
      if (accept && master_read && master_address == 3'h1) begin
        pkt_reads <= pkt_reads + 1;
        if (nack_bit) nack_used <= nack_used + 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (Reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_rd", 32'(master_read), 32'(prev_rd));
        chk("stall_wr", 32'(master_write), 32'(prev_wr));
        chk("stall_addr", 32'(master_address), 32'(prev_addr));
        chk("stall_wdata", master_writedata, prev_wd);
      end
      if (master_read || master_write) begin
        chk("chipselect", 32'(master_chipselect), 32'd1);
        chk("no_overlap", 32'(master_read & master_write), 32'd0);
      end
      if (accept && master_write) begin
        chk("wr_addr", 32'(master_address), 32'h0);
        n_assert++;
        assert (exp_wr.size() != 0) else begin
          n_fail++;
          $error("FAIL wr_unexpected: observed %0h expected none", master_writedata);
        end
        if (exp_wr.size() != 0) chk("wr_data", master_writedata, exp_wr.pop_front());
      end
      if (accept && master_read) begin
        if (master_address == 3'h0) data_reads++;
        else                        status_reads++;
      end
      prev_stall = (master_read || master_write) && master_waitrequest;
      prev_rd    = master_read;
      prev_wr    = master_write;
      prev_addr  = master_address;
      prev_wd    = master_writedata;
    end
  end

  task automatic push_idx(input int i);
    exp_wr.push_back({8'hAB, tbl[i]});
  endtask

  task automatic push_all();
    for (int i = 0; i < 11; i++) push_idx(i);
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
  endtask

  // Runs one sequence and checks the end state against the expected outcome.
  task automatic run_seq(input string tag, input bit extra_start, input bit exp_done,
                         input int exp_eidx, input int exp_dr, input int exp_sr);
    int cyc = 0;
    int dr0 = data_reads;
    int sr0 = status_reads;
    pulse_start();
    if (extra_start) begin
      repeat (20) @(posedge Clk);
      #1 chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
      start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;
    end
    while (!(done || error) && cyc < 20000) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk({tag, "_in_time"}, 32'(cyc < 20000), 32'd1);
    repeat (2) @(posedge Clk); #1;
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(!exp_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    if (!exp_done) chk({tag, "_err_index"}, 32'(err_index), 32'(exp_eidx));
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, "_data_reads"}, 32'(data_reads - dr0), 32'(exp_dr));
    chk({tag, "_status_reads"}, 32'(status_reads - sr0), 32'(exp_sr));
    exp_wr.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_err_index"}, 32'(err_index), 32'd0);
    chk({tag, "_read"}, 32'(master_read), 32'd0);
    chk({tag, "_write"}, 32'(master_write), 32'd0);
    chk({tag, "_cs"}, 32'(master_chipselect), 32'd0);
    chk({tag, "_addr"}, 32'(master_address), 32'd0);
    chk({tag, "_wdata"}, master_writedata, 32'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge Clk);
    #1 chk_outputs_zero("rst");
    Reset = 1'b0;
    repeat (2) @(posedge Clk);

    // Zero-wait, all packets ack immediately.
    push_all();
    run_seq("t1", 1'b0, 1'b1, 0, 11, 11);

    // Status busy for 5 reads per packet; a stray start mid-run must be ignored.
    busy_cfg = 5;
    push_all();
    run_seq("t2", 1'b1, 1'b1, 0, 11, 66);
    busy_cfg = 0;

    // One nack on index 4: that packet goes out twice.
    nack_pkt = tbl[4];
    nack_cfg = 1;
    for (int i = 0; i < 5; i++) push_idx(i);
    push_idx(4);
    for (int i = 5; i < 11; i++) push_idx(i);
    run_seq("t3", 1'b0, 1'b1, 0, 12, 12);

    // Index 2 always nacks: three attempts then error.
    nack_pkt = tbl[2];
    nack_cfg = 1000;
    push_idx(0); push_idx(1); push_idx(2); push_idx(2); push_idx(2);
    run_seq("t4", 1'b0, 1'b0, 2, 5, 5);
    nack_cfg = 0;

    // Three stall cycles on every transfer; error from t4 must clear.
    wait_cfg = 3;
    push_all();
    run_seq("t5", 1'b0, 1'b1, 0, 11, 11);
    wait_cfg = 0;

    // Status stuck busy: POLL_TIMEOUT reads per attempt, three attempts on index 0.
    busy_cfg = 100000;
    push_idx(0); push_idx(0); push_idx(0);
    run_seq("t7", 1'b0, 1'b0, 0, 3, 3072);
    busy_cfg = 0;

    // Reset while the index-6 write is stalled, then a full rerun from index 0.
    wait_cfg = 3;
    for (int i = 0; i < 6; i++) push_idx(i);
    pulse_start();
    cyc = 0;
    while (!(master_write && master_writedata[23:0] == 24'h340A00) && cyc < 5000) begin
      @(negedge Clk);
      cyc++;
    end
    chk("t6_reached_idx6", 32'(cyc < 5000), 32'd1);
    #2 Reset = 1'b1;
    #1 chk_outputs_zero("t6_rst");
    chk("t6_wr_left", 32'(exp_wr.size()), 32'd0);
    exp_wr.delete();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    push_all();
    run_seq("t6", 1'b0, 1'b1, 0, 11, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
